// File: rtl/multi_line_serializer.sv
// Multi-line serializer: buffers LineLen columns of BufferCnt rows each and
// replays them row by row (oldest row first), one pixel per transfer.
// A single RAM bank is filled first and drained afterwards, so the two
// phases never overlap.
module multi_line_serializer #(
  parameter int Width     = 8,
  parameter int LineLen   = 8,
  parameter int BufferCnt = 2
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  input  logic [BufferCnt-1:0][Width-1:0]  data_i,
  input  logic                             valid_i,
  output logic                             ready_o,
  output logic [Width-1:0]                 data_o,
  output logic                             valid_o,
  input  logic                             ready_i,
  output logic                             eol_o,
  output logic                             eob_o
);

  localparam int ColW  = (LineLen > 1) ? $clog2(LineLen) : 1;
  localparam int RowW  = (BufferCnt > 1) ? $clog2(BufferCnt) : 1;
  localparam int WordW = Width * BufferCnt;
  localparam logic [ColW-1:0] ColLast  = ColW'(LineLen - 1);
  localparam logic [RowW-1:0] RowFirst = RowW'(BufferCnt - 1);

  typedef enum logic {FILL, DRAIN} state_e;

  state_e            state_q, state_d;
  logic [ColW-1:0]   col_q, col_d;
  logic [RowW-1:0]   row_q, row_d;
  logic              issued_all_q, issued_all_d;

  logic              accept;
  logic              xfer;
  logic              out_load;
  logic              issue;

  // 1R1W synchronous RAM: one word holds a full column of all rows.
  logic [WordW-1:0]  ram_q [LineLen];
  logic [WordW-1:0]  rd_word_q;

  // Read stage: the RAM output register plus the metadata of the pixel it holds.
  logic              rd_vld_q;
  logic [RowW-1:0]   rd_row_q;
  logic              rd_eol_q;
  logic              rd_eob_q;
  logic [Width-1:0]  rd_pix;
  logic [Width-1:0]  or_chain [BufferCnt+1];

  assign ready_o  = (state_q == FILL);
  assign accept   = valid_i && ready_o;
  assign xfer     = valid_o && ready_i;
  // The output register may take a new pixel when empty or being emptied.
  assign out_load = !valid_o || ready_i;
  // A read is issued only when the read stage is free or drains this cycle,
  // so the RAM output register holds its value while the output is stalled.
  assign issue    = (state_q == DRAIN) && !issued_all_q && (out_load || !rd_vld_q);

  // RAM write during FILL, registered read during DRAIN.
  always_ff @(posedge clk_i) begin
    if (accept) begin
      ram_q[col_q] <= data_i;
    end
    if (issue) begin
      rd_word_q <= ram_q[col_q];
    end
  end

  // Row mux out of the RAM word, built as an AND-OR chain.
  assign or_chain[0] = '0;
  for (genvar gi = 0; gi < BufferCnt; gi++) begin : g_row_sel
    assign or_chain[gi+1] = or_chain[gi] |
        ((rd_row_q == RowW'(gi)) ? rd_word_q[gi*Width +: Width] : '0);
  end
  assign rd_pix = or_chain[BufferCnt];

  // Next-state: column/row counters and FILL/DRAIN sequencing.
  always_comb begin
    state_d      = state_q;
    col_d        = col_q;
    row_d        = row_q;
    issued_all_d = issued_all_q;
    case (state_q)
      FILL: begin
        if (accept) begin
          if (col_q == ColLast) begin
            col_d   = '0;
            state_d = DRAIN;
          end else begin
            col_d = col_q + ColW'(1);
          end
        end
      end
      DRAIN: begin
        if (issue) begin
          if (col_q == ColLast) begin
            col_d = '0;
            if (row_q == '0) begin
              issued_all_d = 1'b1;
            end else begin
              row_d = row_q - RowW'(1);
            end
          end else begin
            col_d = col_q + ColW'(1);
          end
        end
        // The block ends when its final pixel leaves the output register.
        if (xfer && eob_o) begin
          state_d      = FILL;
          issued_all_d = 1'b0;
          row_d        = RowFirst;
          col_d        = '0;
        end
      end
      default: state_d = FILL;
    endcase
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q      <= FILL;
      col_q        <= '0;
      row_q        <= RowFirst;
      issued_all_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      col_q        <= col_d;
      row_q        <= row_d;
      issued_all_q <= issued_all_d;
    end
  end

  // Read-stage bookkeeping: tag the word being read with its row and flags.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rd_vld_q <= 1'b0;
      rd_row_q <= '0;
      rd_eol_q <= 1'b0;
      rd_eob_q <= 1'b0;
    end else if (issue) begin
      rd_vld_q <= 1'b1;
      rd_row_q <= row_q;
      rd_eol_q <= (col_q == ColLast);
      rd_eob_q <= (col_q == ColLast) && (row_q == '0);
    end else if (out_load) begin
      rd_vld_q <= 1'b0;
    end
  end

  // Registered output stage; everything holds while stalled by ready_i.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      valid_o <= 1'b0;
      data_o  <= '0;
      eol_o   <= 1'b0;
      eob_o   <= 1'b0;
    end else if (out_load) begin
      valid_o <= rd_vld_q;
      eol_o   <= rd_vld_q && rd_eol_q;
      eob_o   <= rd_vld_q && rd_eob_q;
      if (rd_vld_q) begin
        data_o <= rd_pix;
      end
    end
  end

endmodule

// File: tb/tb_multi_line_serializer.sv
// Bench for multi_line_serializer: a transpose model checks every cycle of a
// 4x2 instance, and a 2x1 instance is checked against literal values.
module tb_multi_line_serializer;

  localparam int W = 8;
  localparam int L = 4;
  localparam int B = 2;

  typedef struct packed {
    logic         eol;
    logic         eob;
    logic [W-1:0] d;
  } pix_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Main instance signals
  logic                rst_n;
  logic [B-1:0][W-1:0] data_i;
  logic                valid_i, ready_i;
  logic                ready_o, valid_o, eol_o, eob_o;
  logic [W-1:0]        data_o;

  // Small instance signals (LineLen=2, BufferCnt=1)
  logic                rst1_n;
  logic [0:0][W-1:0]   d1;
  logic                v1, r1;
  logic                ro1, vo1, eol1, eob1;
  logic [W-1:0]        do1;

  multi_line_serializer #(.Width(W), .LineLen(L), .BufferCnt(B)) dut (
    .clk_i(clk), .rst_ni(rst_n), .data_i(data_i), .valid_i(valid_i),
    .ready_o(ready_o), .data_o(data_o), .valid_o(valid_o), .ready_i(ready_i),
    .eol_o(eol_o), .eob_o(eob_o)
  );

  multi_line_serializer #(.Width(W), .LineLen(2), .BufferCnt(1)) dut1 (
    .clk_i(clk), .rst_ni(rst1_n), .data_i(d1), .valid_i(v1),
    .ready_o(ro1), .data_o(do1), .valid_o(vo1), .ready_i(r1),
    .eol_o(eol1), .eob_o(eob1)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      if (bad <= 40) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  int                  cyc = 0;
  bit                  m_live = 1'b0;
  bit                  m_fill = 1'b1;
  int                  m_cols = 0;
  int                  m_wait = 0;
  logic [B-1:0][W-1:0] m_colbuf [L];
  pix_t                exp_q[$];
  bit                  exp_valid;
  int                  acc_total = 0;
  int                  blocks_done = 0;
  int                  xfer_total = 0;
  int                  acc_edge_last = 0;
  int                  first_valid_edge = 0;
  logic                prev_valid = 1'b0;

  logic [W-1:0]        log_d[$];
  logic                log_eol[$];
  logic                log_eob[$];
  int                  log_cyc[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Compare process and model update, once per cycle on the falling edge.
  always @(negedge clk) begin
    bit   fill_now;
    pix_t p;
    if (m_wait > 0) m_wait--;
    exp_valid = m_live && !m_fill && (m_wait == 0) && (exp_q.size() > 0);
    if (m_live) begin
      chk("ready_o", 64'(ready_o), 64'(m_fill));
      chk("valid_o", 64'(valid_o), 64'(exp_valid));
      if (exp_valid) begin
        chk("data_o", 64'(data_o), 64'(exp_q[0].d));
        chk("eol_o",  64'(eol_o),  64'(exp_q[0].eol));
        chk("eob_o",  64'(eob_o),  64'(exp_q[0].eob));
      end
      if (valid_o === 1'b1 && prev_valid !== 1'b1) first_valid_edge = cyc;
    end
    prev_valid = valid_o;

    if (rst_n !== 1'b1) begin
      m_live = 1'b1;
      m_fill = 1'b1;
      m_cols = 0;
      m_wait = 0;
      exp_q.delete();
    end else if (m_live) begin
      fill_now = m_fill;
      if (exp_valid && ready_i) begin
        p = exp_q.pop_front();
        log_d.push_back(data_o);
        log_eol.push_back(eol_o);
        log_eob.push_back(eob_o);
        log_cyc.push_back(cyc);
        xfer_total++;
        if (p.eob) begin
          m_fill = 1'b1;
          blocks_done++;
        end
      end
      if (fill_now && valid_i) begin
        m_colbuf[m_cols] = data_i;
        m_cols++;
        acc_total++;
        if (m_cols == L) begin
          // Transpose: oldest row first, each row in column order.
          for (int r = B - 1; r >= 0; r--) begin
            for (int c = 0; c < L; c++) begin
              p.d   = m_colbuf[c][r];
              p.eol = (c == L - 1);
              p.eob = (c == L - 1) && (r == 0);
              exp_q.push_back(p);
            end
          end
          m_fill        = 1'b0;
          m_cols        = 0;
          m_wait        = 3;
          acc_edge_last = cyc + 1;
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  int   v_mode = 0;   // 0 off, 1 until acc_target, 2 random, 4 always
  int   r_mode = 1;   // 0 low, 1 high, 2 toggle, 3 random
  int   acc_target = 0;
  bit   pat_mode = 1'b1;
  int   pat_base = 0;

  task automatic tick();
    @(posedge clk);
    #1;
    case (v_mode)
      1:       valid_i = (acc_total < acc_target);
      2:       valid_i = ($urandom_range(99) < 60);
      4:       valid_i = 1'b1;
      default: valid_i = 1'b0;
    endcase
    case (r_mode)
      0:       ready_i = 1'b0;
      2:       ready_i = !ready_i;
      3:       ready_i = ($urandom_range(99) < 65);
      default: ready_i = 1'b1;
    endcase
    if (pat_mode) begin
      data_i[1] = 8'(pat_base + 16 + m_cols);
      data_i[0] = 8'(pat_base + m_cols);
    end else begin
      data_i = 16'($urandom);
    end
  endtask

  task automatic wait_blocks(input int target, input int budget, input string name);
    int n = 0;
    while (blocks_done < target && n < budget) begin
      tick();
      n++;
    end
    if (blocks_done < target) begin
      total++;
      bad++;
      $display("FAIL %s timeout: blocks %0d required %0d", name, blocks_done, target);
    end
  endtask

  task automatic run_block(input string name);
    acc_target = acc_total + L;
    v_mode     = 1;
    wait_blocks(blocks_done + 1, 300, name);
    v_mode     = 0;
  endtask

  task automatic clear_log();
    log_d.delete();
    log_eol.delete();
    log_eob.delete();
    log_cyc.delete();
  endtask

  // Checks a logged block against the literal row1 = hi+c, row0 = lo+c pattern.
  task automatic check_block(input string name, input int hi, input int lo);
    logic [7:0] exp_eol = 8'b1000_1000;
    logic [7:0] exp_eob = 8'b1000_0000;
    chk({name, " count"}, 64'(log_d.size()), 64'(8));
    if (log_d.size() == 8) begin
      for (int i = 0; i < 8; i++) begin
        chk($sformatf("%s d[%0d]", name, i), 64'(log_d[i]),
            64'((i < 4) ? (hi + i) : (lo + i - 4)));
        chk($sformatf("%s eol[%0d]", name, i), 64'(log_eol[i]), 64'(exp_eol[i]));
        chk($sformatf("%s eob[%0d]", name, i), 64'(log_eob[i]), 64'(exp_eob[i]));
      end
    end
  endtask

  initial begin
    int b0, t0, n;
    rst_n = 1'b0; valid_i = 1'b0; ready_i = 1'b1; data_i = '0;
    rst1_n = 1'b0; v1 = 1'b0; r1 = 1'b1; d1 = '0;
    tick();
    tick();
    rst_n = 1'b1;
    chk("reset ready_o", 64'(ready_o), 64'(1));
    chk("reset valid_o", 64'(valid_o), 64'(0));
    chk("reset data_o",  64'(data_o),  64'(0));
    chk("reset eol_o",   64'(eol_o),   64'(0));
    chk("reset eob_o",   64'(eob_o),   64'(0));

    // Back-to-back columns, ready_i high.
    clear_log();
    pat_base = 0; r_mode = 1;
    run_block("A");
    check_block("A", 16, 0);
    if (log_cyc.size() == 8) chk("A burst span", 64'(log_cyc[7] - log_cyc[0]), 64'(7));
    chk("A latency", 64'(first_valid_edge - acc_edge_last), 64'(2));

    // Same block with ready_i toggling every cycle.
    clear_log();
    r_mode = 2;
    run_block("B");
    check_block("B", 16, 0);

    // valid_i held high across two blocks.
    clear_log();
    r_mode = 1; v_mode = 4;
    wait_blocks(blocks_done + 2, 300, "C");
    v_mode = 0;
    chk("C transfers", 64'(log_d.size()), 64'(16));
    chk("C latency", 64'(first_valid_edge - acc_edge_last), 64'(2));

    // Reset in the middle of a fill, then in the middle of a drain.
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("midfill rst ready_o", 64'(ready_o), 64'(1));
    clear_log();
    pat_base = 32; acc_target = acc_total + L; v_mode = 1;
    n = 0;
    while (log_d.size() < 3 && n < 300) begin
      tick();
      n++;
    end
    chk("D three transfers", 64'(log_d.size()), 64'(3));
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("D rst valid_o", 64'(valid_o), 64'(0));
    chk("D rst ready_o", 64'(ready_o), 64'(1));
    clear_log();
    pat_base = 64;
    run_block("D");
    check_block("D", 80, 64);

    // Random traffic over 1000 blocks.
    pat_mode = 1'b0; v_mode = 2; r_mode = 3;
    b0 = blocks_done; t0 = xfer_total;
    wait_blocks(b0 + 1000, 70000, "E");
    v_mode = 0;
    chk("E transfers", 64'(xfer_total - t0), 64'((blocks_done - b0) * 8));

    // Single-row instance: columns 5, 6.
    r_mode = 1;
    rst1_n = 1'b1;
    chk("F reset ready_o", 64'(ro1), 64'(1));
    v1 = 1'b1; d1 = 8'd5;
    tick();
    d1 = 8'd6;
    tick();
    v1 = 1'b0;
    tick();
    chk("F latency valid_o", 64'(vo1), 64'(0));
    tick();
    chk("F p0 valid", 64'(vo1),  64'(1));
    chk("F p0 data",  64'(do1),  64'(5));
    chk("F p0 eol",   64'(eol1), 64'(0));
    chk("F p0 eob",   64'(eob1), 64'(0));
    tick();
    chk("F p1 valid", 64'(vo1),  64'(1));
    chk("F p1 data",  64'(do1),  64'(6));
    chk("F p1 eol",   64'(eol1), 64'(1));
    chk("F p1 eob",   64'(eob1), 64'(1));
    tick();
    chk("F end valid_o", 64'(vo1), 64'(0));
    chk("F end ready_o", 64'(ro1), 64'(1));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/multi_line_serializer.md
MULTI_LINE_SERIALIZER -- requirements
Module: multi_line_serializer

Interface
REQ-001 Parameter Width, default 8: bits per pixel.
REQ-002 Parameter LineLen, default 8: columns per line (>=2).
REQ-003 Parameter BufferCnt, default 2: rows per block (>=1).
REQ-004 clk_i  input  1  sole clock; all state updates on rising edge.
REQ-005 rst_ni  input  1  reset, synchronous, active-low.
REQ-006 data_i  input  [BufferCnt-1:0][Width-1:0]  one column; index 0 = newest row, index BufferCnt-1 = oldest row.
REQ-007 valid_i  input  1  column valid.
REQ-008 ready_o  output  1  block accepts a column.
REQ-009 data_o  output  Width  serialized pixel.
REQ-010 valid_o  output  1  data_o valid.
REQ-011 ready_i  input  1  downstream accepts pixel.
REQ-012 eol_o  output  1  high with the last pixel of each row (column LineLen-1).
REQ-013 eob_o  output  1  high with the final pixel of the block (row 0, column LineLen-1).

Function
REQ-014 Column accept = valid_i && ready_o; pixel transfer = valid_o && ready_i.
REQ-015 Two states: FILL (ready_o=1, no new pixels issued) and DRAIN (ready_o=0).
REQ-016 FILL: each accept stores data_i at column index col (0..LineLen-1), then col increments.
REQ-017 Accept at col=LineLen-1: col wraps to 0, state -> DRAIN.
REQ-018 Storage: one ram_1r1w_sync, width Width*BufferCnt, depth LineLen; one synchronous-read cycle of latency.
REQ-019 DRAIN order: row BufferCnt-1 down to row 0; within each row, column 0 up to LineLen-1 (oldest line emitted first, raster order).
REQ-020 Output stage registered; data_o/eol_o/eob_o held stable while valid_o && !ready_i.
REQ-021 First valid_o asserts exactly 2 cycles after the final FILL accept edge.
REQ-022 With ready_i held high, one pixel transfers every cycle; no bubbles within or between rows of a block.
REQ-023 ready_i low for N cycles stalls the sequence exactly N cycles; no pixel dropped or duplicated.
REQ-024 Transfer with eob_o=1: state -> FILL, ready_o=1 on the next cycle; valid_o=0 unless a new block has completed.
REQ-025 Reads during DRAIN only; a column is never written before its pixels are emitted (single-bank, no overlap).
REQ-026 Counter widths $clog2(LineLen) and $clog2(BufferCnt), minimum 1 bit; wrap compares to LineLen-1 and 0 exactly.
REQ-027 BufferCnt=1: eob_o coincides with every eol_o.
REQ-028 valid_i while ready_o=0 is ignored; data_i is not sampled.

Reset
REQ-029 rst_ni low at a clock edge: state=FILL, col=0, row=BufferCnt-1, valid_o=0, eol_o=0, eob_o=0, data_o=0; ready_o=1 on the first cycle after reset deasserts.
REQ-030 Reset mid-FILL or mid-DRAIN discards the partial block; RAM contents need not be cleared (never re-emitted without a full refill).

Verification
REQ-031 Width=8, LineLen=4, BufferCnt=2; columns {row1,row0} = {10,00},{11,01},{12,02},{13,03} back-to-back, ready_i=1 -> data_o 10,11,12,13,00,01,02,03 on consecutive cycles; eol_o at 13 and 03; eob_o at 03 only.
REQ-032 Same stimulus, ready_i toggled 1/0 every cycle -> identical sequence, data_o stable on stalled cycles, 8 transfers total.
REQ-033 valid_i held high continuously -> ready_o=0 for the whole drain, 4 accepts per block, second block's first pixel 2 cycles after its 4th accept.
REQ-034 rst_ni low for 1 cycle after the 3rd pixel transfer -> valid_o=0, ready_o=1 next cycle; new block emits only its own data.
REQ-035 BufferCnt=1, LineLen=2; columns 5,6 -> data_o 5,6 with eol_o=eob_o=1 on 6.
REQ-036 Random valid_i/ready_i over 1000 blocks vs. transpose model -> zero mismatches, one pixel per transfer.
